// File: rtl/reg_index_encoder_if.sv
// Handshake bundle for reg_index_encoder: mask input side and index output side.
// master = producer/consumer environment, slave = the encoder itself.
interface reg_index_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_mask;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_index;
   logic        out_last;

   modport master (
      output in_valid, in_mask, out_ready,
      input  in_ready, out_valid, out_index, out_last
   );

   modport slave (
      input  in_valid, in_mask, out_ready,
      output in_ready, out_valid, out_index, out_last
   );
endinterface

// File: rtl/reg_index_encoder.sv
// Serialises a 32-bit multi-hot register mask into 5-bit indices, lowest first.
// Ports: clk, reset (async, active-high), busy (EMIT state), bus (slave handshake).
module reg_index_encoder (
   input  logic clk,
   input  logic reset,
   output logic busy,
   reg_index_encoder_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   logic [0:0]  state;
   logic [31:0] pending;
   logic [31:0] pending_clr;
   logic [4:0]  low_idx;
   logic        single;

   // Priority encode the lowest set bit; zero when nothing is pending.
   always_comb begin
      low_idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (pending[i]) low_idx = 5'(i);
      end
   end

   // Clearing the lowest set bit; an empty result means one bit was left.
   assign pending_clr = pending & (pending - 32'd1);
   assign single      = (pending != '0) && (pending_clr == '0);

   // All outputs come from registered state only.
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == EMIT);
   assign bus.out_index = low_idx;
   assign bus.out_last  = (state == EMIT) && single;
   assign busy          = (state == EMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         case (state)
            IDLE: begin
               // An all-zero mask is consumed with no output.
               if (bus.in_valid && (bus.in_mask != '0)) begin
                  pending <= bus.in_mask;
                  state   <= EMIT;
               end
            end
            EMIT: begin
               if (bus.out_ready) begin
                  pending <= pending_clr;
                  if (single) state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               pending <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_reg_index_encoder.sv
// Self-checking bench for reg_index_encoder: vector table, corner sequences
// and randomized masks against a queue-based reference model.
module tb_reg_index_encoder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic busy;
   int   total = 0;
   int   bad = 0;

   reg_index_encoder_if bus ();

   reg_index_encoder dut (
      .clk   (clk),
      .reset (reset),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] mask;
      int          stall;
      int          n;
      logic [4:0]  first;
      logic [4:0]  fin;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   // Called at a negedge; presents the mask for exactly one rising edge.
   task automatic send(input logic [31:0] m);
      check("send_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_mask  = m;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_mask  = 'x;
   endtask

   // Model: the expected stream is simply the set bit positions, ascending.
   task automatic drain(input logic [31:0] m, input int stall, input bit rnd,
                        output int n, output logic [4:0] first,
                        output logic [4:0] fin);
      int         exp_q[$];
      bit         prev_stall = 1'b0;
      logic [4:0] prev_idx = '0;
      bit         done = 1'b0;
      for (int i = 0; i < 32; i++) if (m[i]) exp_q.push_back(i);
      n = 0;
      first = '0;
      fin = '0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
         check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
         check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_q.size() == 0});
         if (exp_q.size() == 0) begin
            check("idle_last", {31'd0, bus.out_last}, 32'd0);
            check("idle_index", {27'd0, bus.out_index}, 32'd0);
            bus.out_ready = 1'b0;
            done = 1'b1;
         end else begin
            check("out_index", {27'd0, bus.out_index}, exp_q[0]);
            check("out_last", {31'd0, bus.out_last}, {31'd0, exp_q.size() == 1});
            if (prev_stall)
               check("hold_index", {27'd0, bus.out_index}, {27'd0, prev_idx});
            bus.out_ready = (cyc >= stall) &&
                            (rnd ? ($urandom_range(1, 0) == 1) : 1'b1);
            if (bus.out_valid && bus.out_ready) begin
               if (n == 0) first = bus.out_index;
               fin = bus.out_index;
               n++;
            end
            if (bus.out_ready) void'(exp_q.pop_front());
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_idx   = bus.out_index;
            @(negedge clk);
         end
      end
      if (!done) check("drain_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[8];
      int          n;
      logic [4:0]  f;
      logic [4:0]  l;
      logic [31:0] m;

      vt[0] = '{32'h0000_0008, 0, 1, 5'd3, 5'd3};
      vt[1] = '{32'h8000_0001, 0, 2, 5'd0, 5'd31};
      vt[2] = '{32'hFFFF_FFFF, 0, 32, 5'd0, 5'd31};
      vt[3] = '{32'h0000_0014, 3, 2, 5'd2, 5'd4};
      vt[4] = '{32'h0000_0000, 0, 0, 5'd0, 5'd0};
      vt[5] = '{32'h0000_0002, 1, 1, 5'd1, 5'd1};
      vt[6] = '{32'h4000_0000, 2, 1, 5'd30, 5'd30};
      vt[7] = '{32'h8000_0000, 0, 1, 5'd31, 5'd31};

      bus.in_valid  = 1'b0;
      bus.in_mask   = '0;
      bus.out_ready = 1'b0;

      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out_index", {27'd0, bus.out_index}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // First send right after release: first edge behaves as IDLE.
      for (int k = 0; k < 8; k++) begin
         send(vt[k].mask);
         drain(vt[k].mask, vt[k].stall, 1'b0, n, f, l);
         check("vec_count", n, vt[k].n);
         if (vt[k].n != 0) begin
            check("vec_first", {27'd0, f}, {27'd0, vt[k].first});
            check("vec_final", {27'd0, l}, {27'd0, vt[k].fin});
         end
      end

      // Reset in the middle of emitting 0xFF after three handshakes.
      send(32'h0000_00FF);
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_valid", {31'd0, bus.out_valid}, 32'd1);
      check("mid_index", {27'd0, bus.out_index}, 32'd3);
      #2 reset = 1'b1;
      #1;
      check("async_valid", {31'd0, bus.out_valid}, 32'd0);
      check("async_busy", {31'd0, busy}, 32'd0);
      check("async_last", {31'd0, bus.out_last}, 32'd0);
      check("async_index", {27'd0, bus.out_index}, 32'd0);
      check("async_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      check("held_valid", {31'd0, bus.out_valid}, 32'd0);
      reset = 1'b0;
      bus.out_ready = 1'b0;
      send(32'h0000_0002);
      drain(32'h0000_0002, 0, 1'b0, n, f, l);
      check("post_rst_count", n, 1);
      check("post_rst_index", {27'd0, f}, 32'd1);

      // Randomized masks with random backpressure.
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(3, 0))
            0: m = $urandom;
            1: m = $urandom & $urandom & $urandom;
            2: m = 32'd1 << $urandom_range(31, 0);
            default: m = ($urandom_range(1, 0) == 1) ? 32'hFFFF_FFFF : 32'h0;
         endcase
         send(m);
         drain(m, 0, 1'b1, n, f, l);
         check("rnd_count", n, $countones(m));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_index_encoder.md
REG_INDEX_ENCODER -- requirements
Module: reg_index_encoder

Interface
REQ-001 Parameters: none; width fixed at 32 register slots, 5-bit index.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_valid  input  1  in_mask is valid this cycle.
REQ-005 in_ready  output  1  block can accept a new mask this cycle.
REQ-006 in_mask  input  32  multi-hot register mask; bit i set = register i selected.
REQ-007 out_valid  output  1  out_index holds a valid register number.
REQ-008 out_ready  input  1  consumer accepts out_index this cycle.
REQ-009 out_index  output  5  register number of the lowest set bit still pending.
REQ-010 out_last  output  1  current out_index is the final pending bit of the mask.
REQ-011 busy  output  1  high while in EMIT state.

Function
REQ-012 The block SHALL invert the write decoder: convert a 32-bit mask into a serial stream of 5-bit register indices, lowest index first.
REQ-013 States SHALL be IDLE and EMIT; a 32-bit pending register holds the not-yet-emitted bits.
REQ-014 IDLE: in_ready=1, out_valid=0, busy=0.
REQ-015 IDLE, in_valid=1, in_mask!=0: at the edge, pending<=in_mask, state->EMIT.
REQ-016 IDLE, in_valid=1, in_mask==0: mask accepted and discarded; state stays IDLE, no output produced.
REQ-017 in_mask SHALL be ignored (may be X) when in_valid=0 or in_ready=0.
REQ-018 EMIT: in_ready=0, out_valid=1, busy=1; out_index = position of lowest set bit of pending.
REQ-019 out_last SHALL be 1 exactly when pending has one bit set; 0 whenever out_valid=0.
REQ-020 Output handshake = out_valid & out_ready; on handshake the lowest set bit of pending is cleared at the edge.
REQ-021 Handshake with out_last=1: state->IDLE, pending<=0; in_ready high the following cycle (no overlap of last output and new input acceptance).
REQ-022 out_valid=1 with out_ready=0: out_index and out_last SHALL hold stable until handshake.
REQ-023 Latency: mask accepted at edge N -> first out_valid in the cycle after edge N; then one index per cycle while out_ready=1.
REQ-024 Full mask (0xFFFF_FFFF) SHALL emit 32 indices 0..31 with no wrap, no skip, no duplicate.
REQ-025 out_index, out_last and out_valid SHALL derive from registered state only (no combinational path from in_* or out_ready).
REQ-026 Index 31 and index 0 SHALL be handled identically to interior bits (no boundary special case in behaviour).

Reset
REQ-027 Reset asserted: state=IDLE, pending=0, out_valid=0, out_last=0, busy=0, out_index=0, in_ready=1 while reset held low-to-release transitions complete.
REQ-028 Reset mid-EMIT SHALL abandon the remaining indices; out_valid drops without waiting for a clock edge.
REQ-029 After reset release the first edge SHALL behave as IDLE (may accept a mask).

Verification
REQ-030 mask 0x0000_0008, out_ready=1 -> one output index=3, out_last=1; in_ready=1 the next cycle.
REQ-031 mask 0x8000_0001, out_ready=1 -> index 0 (last=0) then 31 (last=1) in consecutive cycles.
REQ-032 mask 0xFFFF_FFFF, out_ready=1 -> indices 0..31 over 32 cycles, out_last only with 31, in_ready=0 throughout.
REQ-033 mask 0x0000_0014, out_ready=0 for 3 cycles -> index 2 held stable 3 cycles, then 2, 4 (last) once out_ready=1.
REQ-034 mask 0x0000_0000 with in_valid=1 -> accepted, out_valid never rises, in_ready stays 1.
REQ-035 mask 0x0000_00FF, reset asserted after 3 handshakes -> out_valid=0 immediately, no further indices; new mask 0x2 after release -> index 1, last=1.
